// File: rtl/gpio_ctrl_pkg.sv
// rtl/gpio_ctrl_pkg.sv - register addresses and FSM states for the GPIO bank controller
package gpio_ctrl_pkg;

   localparam logic [1:0] ADDR_OUT    = 2'd0;
   localparam logic [1:0] ADDR_DIR    = 2'd1;
   localparam logic [1:0] ADDR_IN     = 2'd2;
   localparam logic [1:0] ADDR_STATUS = 2'd3;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      TURN  = 2'd1,
      APPLY = 2'd2
   } state_t;

endpackage

// File: rtl/gpio_in_sync.sv
// rtl/gpio_in_sync.sv - per-bit multi-stage synchroniser for asynchronous pad inputs
module gpio_in_sync #(
   parameter int W      = 8,
   parameter int STAGES = 2
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   logic [STAGES-1:0][W-1:0] chain;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         chain <= '0;
      end else begin
         chain <= {chain[STAGES-2:0], d};
      end
   end

   assign q = chain[STAGES-1];

endmodule

// File: rtl/gpio_bank_ctrl.sv
// rtl/gpio_bank_ctrl.sv - GPIO bank register file with break-before-make direction sequencing
// Optional rising-edge status/irq logic is built when GPIO_EDGE_IRQ_EN is defined.
module gpio_bank_ctrl
   import gpio_ctrl_pkg::*;
#(
   parameter int N_PADS      = 8,
   parameter int TURN_CYC    = 4,
   parameter int SYNC_STAGES = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [1:0]        req_addr,
   input  logic [N_PADS-1:0] req_wdata,
   output logic              rsp_valid,
   output logic [N_PADS-1:0] rsp_rdata,
   output logic [N_PADS-1:0] gpio_dir,
   output logic [N_PADS-1:0] gpio_out,
   input  logic [N_PADS-1:0] gpio_in,
   output logic              busy,
   output logic              irq
);

   localparam logic [7:0] TURN_M1 = (TURN_CYC > 0) ? 8'(TURN_CYC - 1) : 8'd0;

   state_t            state;
   logic [7:0]        cnt;
   logic [N_PADS-1:0] dir_tgt;
   logic [N_PADS-1:0] s_in;
   logic [N_PADS-1:0] status;
   logic [N_PADS-1:0] rd_mux;
   logic [N_PADS-1:0] dir_on;
   logic              acc;

   gpio_in_sync #(
      .W      (N_PADS),
      .STAGES (SYNC_STAGES)
   ) u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (gpio_in),
      .q     (s_in)
   );

   assign req_ready = (state == IDLE);
   assign acc       = req_valid && req_ready;
   assign dir_on    = req_wdata & ~gpio_dir;

   always_comb begin
      rd_mux = '0;
      case (req_addr)
         ADDR_OUT:    rd_mux = gpio_out;
         ADDR_DIR:    rd_mux = dir_tgt;
         ADDR_IN:     rd_mux = s_in;
         ADDR_STATUS: rd_mux = status;
         default:     rd_mux = '0;
      endcase
   end

`ifdef GPIO_EDGE_IRQ_EN
   logic [N_PADS-1:0] in_prev;
   logic [N_PADS-1:0] rise;
   logic [N_PADS-1:0] clr;
   logic [N_PADS-1:0] status_nxt;

   // Driven pads are ignored; a simultaneous edge beats a W1C clear.
   assign rise       = s_in & ~in_prev & ~gpio_dir;
   assign clr        = (acc && req_we && req_addr == ADDR_STATUS) ? req_wdata : '0;
   assign status_nxt = (status & ~clr) | rise;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         in_prev <= '0;
         status  <= '0;
         irq     <= 1'b0;
      end else begin
         in_prev <= s_in;
         status  <= status_nxt;
         irq     <= |status_nxt;
      end
   end
`else
   assign status = '0;
   assign irq    = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         cnt       <= '0;
         busy      <= 1'b0;
         dir_tgt   <= '0;
         gpio_dir  <= '0;
         gpio_out  <= '0;
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
      end else begin
         rsp_valid <= acc;
         rsp_rdata <= (acc && !req_we) ? rd_mux : '0;
         case (state)
            IDLE: begin
               if (acc && req_we) begin
                  case (req_addr)
                     ADDR_OUT: gpio_out <= req_wdata;
                     ADDR_DIR: begin
                        dir_tgt <= req_wdata;
                        if (dir_on == '0 || TURN_CYC == 0) begin
                           gpio_dir <= req_wdata;
                        end else begin
                           // Drop disables now, hold new enables until the turnaround ends.
                           gpio_dir <= gpio_dir & req_wdata;
                           cnt      <= TURN_M1;
                           busy     <= 1'b1;
                           state    <= TURN;
                        end
                     end
                     default: ;
                  endcase
               end
            end
            TURN: begin
               if (cnt == 8'd0) begin
                  state <= APPLY;
               end else begin
                  cnt <= cnt - 8'd1;
               end
            end
            APPLY: begin
               gpio_dir <= dir_tgt;
               busy     <= 1'b0;
               state    <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_gpio_bank_ctrl.sv
// tb/tb_gpio_bank_ctrl.sv - scoreboard bench for gpio_bank_ctrl (edge tests with GPIO_EDGE_IRQ_EN)
module tb_gpio_bank_ctrl;

   logic       clk;
   logic       rst_n;
   logic       req_valid;
   logic       req_ready;
   logic       req_we;
   logic [1:0] req_addr;
   logic [7:0] req_wdata;
   logic       rsp_valid;
   logic [7:0] rsp_rdata;
   logic [7:0] gpio_dir;
   logic [7:0] gpio_out;
   logic [7:0] gpio_in;
   logic       busy;
   logic       irq;

   int         n_checks = 0;
   int         n_errors = 0;
   logic [7:0] sb[$];

   gpio_bank_ctrl #(
      .N_PADS      (8),
      .TURN_CYC    (4),
      .SYNC_STAGES (2)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_we    (req_we),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .rsp_valid (rsp_valid),
      .rsp_rdata (rsp_rdata),
      .gpio_dir  (gpio_dir),
      .gpio_out  (gpio_out),
      .gpio_in   (gpio_in),
      .busy      (busy),
      .irq       (irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Called and returning at a falling edge; returns one cycle after the accept edge.
   task automatic bus(input logic we, input logic [1:0] addr, input logic [7:0] wdata,
                      input logic [7:0] exp);
      int n = 0;
      req_valid = 1'b1;
      req_we    = we;
      req_addr  = addr;
      req_wdata = wdata;
      while (!req_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!req_ready) check("ready_timeout", {31'd0, req_ready}, 32'd1);
      else sb.push_back(we ? 8'h00 : exp);
      @(negedge clk);
      req_valid = 1'b0;
   endtask

   always @(negedge clk) begin
      if (rst_n && rsp_valid) begin
         if (sb.size() == 0) check("rsp_unexpected", {31'd0, rsp_valid}, 32'd0);
         else check("rsp_rdata", rsp_rdata, sb.pop_front());
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n     = 1'b0;
      req_valid = 1'b0;
      req_we    = 1'b0;
      req_addr  = 2'd0;
      req_wdata = 8'h00;
      gpio_in   = 8'hA5;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      check("rst_dir", gpio_dir, 8'h00);
      check("rst_out", gpio_out, 8'h00);
      check("rst_rsp_valid", rsp_valid, 1'b0);
      check("rst_rdata", rsp_rdata, 8'h00);
      check("rst_busy", busy, 1'b0);
      check("rst_irq", irq, 1'b0);
      check("rst_ready", req_ready, 1'b1);

      repeat (2) @(negedge clk);
      bus(1'b0, 2'd2, 8'h00, 8'hA5);

      bus(1'b1, 2'd0, 8'h3C, 8'h00);
      check("out_applied", gpio_out, 8'h3C);
      bus(1'b0, 2'd0, 8'h00, 8'h3C);
      bus(1'b0, 2'd1, 8'h00, 8'h00);

      // Enable 0x0F: five cycles of turnaround before the pads drive.
      bus(1'b1, 2'd1, 8'h0F, 8'h00);
      for (int i = 1; i <= 5; i++) begin
         check("turn_busy", busy, 1'b1);
         check("turn_ready", req_ready, 1'b0);
         check("turn_dir_hold", gpio_dir, 8'h00);
         @(negedge clk);
      end
      check("turn_dir_applied", gpio_dir, 8'h0F);
      check("turn_busy_done", busy, 1'b0);
      bus(1'b0, 2'd1, 8'h00, 8'h0F);

      // 0x0F -> 0xF0: disable at once; a read held during turnaround waits.
      bus(1'b1, 2'd1, 8'hF0, 8'h00);
      check("swap_break", gpio_dir, 8'h00);
      check("swap_busy", busy, 1'b1);
      bus(1'b0, 2'd0, 8'h00, 8'h3C);
      check("swap_make", gpio_dir, 8'hF0);

      bus(1'b1, 2'd1, 8'h30, 8'h00);
      check("disable_only_dir", gpio_dir, 8'h30);
      check("disable_only_busy", busy, 1'b0);

      // Reset in the middle of a turnaround discards the pending enable.
      bus(1'b1, 2'd1, 8'hFF, 8'h00);
      check("pend_dir", gpio_dir, 8'h30);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("midrst_dir", gpio_dir, 8'h00);
      check("midrst_busy", busy, 1'b0);
      check("midrst_out", gpio_out, 8'h00);
      check("midrst_ready", req_ready, 1'b1);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (7) @(negedge clk);
      check("postrst_dir", gpio_dir, 8'h00);
      check("postrst_busy", busy, 1'b0);
      bus(1'b0, 2'd1, 8'h00, 8'h00);
      bus(1'b0, 2'd0, 8'h00, 8'h00);

`ifdef GPIO_EDGE_IRQ_EN
      bus(1'b1, 2'd3, 8'hFF, 8'h00);
      gpio_in = 8'hA1;
      repeat (4) @(negedge clk);
      bus(1'b0, 2'd3, 8'h00, 8'h00);
      check("edge_irq_idle", irq, 1'b0);
      gpio_in = 8'hA5;
      repeat (4) @(negedge clk);
      bus(1'b0, 2'd3, 8'h00, 8'h04);
      check("edge_irq_set", irq, 1'b1);
      bus(1'b1, 2'd3, 8'h04, 8'h00);
      check("edge_irq_clr", irq, 1'b0);
      bus(1'b1, 2'd1, 8'h04, 8'h00);
      repeat (6) @(negedge clk);
      check("edge_dir_driven", gpio_dir, 8'h04);
      gpio_in = 8'hA1;
      repeat (4) @(negedge clk);
      gpio_in = 8'hA5;
      repeat (4) @(negedge clk);
      bus(1'b0, 2'd3, 8'h00, 8'h00);
      check("edge_driven_irq", irq, 1'b0);
`else
      bus(1'b0, 2'd3, 8'h00, 8'h00);
      bus(1'b1, 2'd3, 8'hFF, 8'h00);
      check("noirq_irq", irq, 1'b0);
`endif

      repeat (3) @(negedge clk);
      check("sb_drained", sb.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
